// File: rtl/i2c_slave.sv
// I2C target with an 8-bit register pointer: writes stream through writeData/writeStrobe,
// reads fetch readData on readStrobe. SCL/SDA are oversampled on clock.
module i2c_slave #(
  parameter logic [6:0] DEVICE_ADDRESS = 7'h3C
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       SCL,
  input  logic       sdaIn,
  output logic       sdaDriven,
  output logic [7:0] regAddress,
  output logic [7:0] writeData,
  output logic       writeStrobe,
  input  logic [7:0] readData,
  output logic       readStrobe,
  output logic       busy
);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] ADDR      = 4'd1;
  localparam logic [3:0] ADDR_ACK  = 4'd2;
  localparam logic [3:0] REG       = 4'd3;
  localparam logic [3:0] REG_ACK   = 4'd4;
  localparam logic [3:0] WDATA     = 4'd5;
  localparam logic [3:0] WDATA_ACK = 4'd6;
  localparam logic [3:0] RDATA     = 4'd7;
  localparam logic [3:0] RDATA_ACK = 4'd8;
  localparam logic [3:0] IGNORE    = 4'd9;

  logic [1:0] sclSync, sdaSync;
  logic       sclPrev, sdaPrev;
  logic [3:0] state, bitCnt;
  logic [7:0] rxShift, txShift;
  logic       rnw;

  logic scl, sda, sclRise, sclFall, startCond, stopCond, readLoad;
  logic [7:0] rxByte;

  assign scl       = sclSync[1];
  assign sda       = sdaSync[1];
  assign sclRise   = scl & ~sclPrev;
  assign sclFall   = ~scl & sclPrev;
  assign startCond = scl & sclPrev & sdaPrev & ~sda;
  assign stopCond  = scl & sclPrev & ~sdaPrev & sda;
  assign rxByte    = {rxShift[6:0], sda};

  // Fetch happens on the falling edge that opens a transmit byte; RDATA_ACK only
  // survives to a falling edge when the master acknowledged.
  assign readLoad   = sclFall & (((state == ADDR_ACK) & rnw) | (state == RDATA_ACK));
  assign readStrobe = ~reset & readLoad;

  always_ff @(posedge clock) begin
    if (reset) begin
      sclSync     <= 2'b11;
      sdaSync     <= 2'b11;
      sclPrev     <= 1'b1;
      sdaPrev     <= 1'b1;
      state       <= IDLE;
      bitCnt      <= 4'd0;
      rxShift     <= 8'h00;
      txShift     <= 8'h00;
      rnw         <= 1'b0;
      sdaDriven   <= 1'b0;
      regAddress  <= 8'h00;
      writeData   <= 8'h00;
      writeStrobe <= 1'b0;
      busy        <= 1'b0;
    end else begin
      sclSync     <= {sclSync[0], SCL};
      sdaSync     <= {sdaSync[0], sdaIn};
      sclPrev     <= scl;
      sdaPrev     <= sda;
      writeStrobe <= 1'b0;
      if (writeStrobe) regAddress <= regAddress + 8'd1;

      if (startCond) begin
        state     <= ADDR;
        bitCnt    <= 4'd0;
        sdaDriven <= 1'b0;
        busy      <= 1'b0;
      end else if (stopCond) begin
        state     <= IDLE;
        sdaDriven <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          ADDR, REG, WDATA: begin
            if (sclRise && bitCnt < 4'd8) begin
              rxShift <= rxByte;
              bitCnt  <= bitCnt + 4'd1;
              if (bitCnt == 4'd7) begin
                if (state == REG) regAddress <= rxByte;
                if (state == WDATA) begin
                  writeData   <= rxByte;
                  writeStrobe <= 1'b1;
                end
              end
            end
            if (sclFall && bitCnt == 4'd8) begin
              if (state == ADDR && rxShift[7:1] != DEVICE_ADDRESS) begin
                state <= IGNORE;
              end else begin
                sdaDriven <= 1'b1;
                case (state)
                  ADDR:    state <= ADDR_ACK;
                  REG:     state <= REG_ACK;
                  default: state <= WDATA_ACK;
                endcase
                if (state == ADDR) begin
                  busy <= 1'b1;
                  rnw  <= rxShift[0];
                end
              end
            end
          end
          ADDR_ACK, REG_ACK, WDATA_ACK: begin
            if (sclFall) begin
              bitCnt <= 4'd0;
              if (readLoad) begin
                txShift   <= readData;
                sdaDriven <= ~readData[7];
                state     <= RDATA;
              end else begin
                sdaDriven <= 1'b0;
                state     <= (state == ADDR_ACK) ? REG : WDATA;
              end
            end
          end
          RDATA: begin
            if (sclRise && bitCnt < 4'd8) bitCnt <= bitCnt + 4'd1;
            if (sclFall) begin
              if (bitCnt == 4'd8) begin
                sdaDriven <= 1'b0;
                state     <= RDATA_ACK;
              end else begin
                txShift   <= {txShift[6:0], 1'b0};
                sdaDriven <= ~txShift[6];
              end
            end
          end
          RDATA_ACK: begin
            if (sclRise) begin
              if (sda) begin
                state <= IGNORE;
                busy  <= 1'b0;
              end else begin
                regAddress <= regAddress + 8'd1;
              end
            end
            if (sclFall) begin
              bitCnt    <= 4'd0;
              txShift   <= readData;
              sdaDriven <= ~readData[7];
              state     <= RDATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged I2C master on a wired-AND bus, write-vector table,
// strobe scoreboard, and hand sequences for read, abort and reset.
module tb_i2c_slave;
  localparam time Q = 50;  // quarter SCL period; clock is 10 ns so SCL runs at clock/20

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       SCL   = 1'b1;
  logic       sdaM  = 1'b1;
  logic       sdaBus, sdaDriven, writeStrobe, readStrobe, busy;
  logic [7:0] regAddress, writeData, readData;

  assign sdaBus   = sdaM & ~sdaDriven;
  assign readData = 8'h20 + regAddress;

  i2c_slave #(.DEVICE_ADDRESS(7'h3C)) dut (
    .clock(clock), .reset(reset), .SCL(SCL), .sdaIn(sdaBus), .sdaDriven(sdaDriven),
    .regAddress(regAddress), .writeData(writeData), .writeStrobe(writeStrobe),
    .readData(readData), .readStrobe(readStrobe), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] dev;
    logic [7:0] regB;
    int         nData;
    logic [7:0] d0;
    logic [7:0] d1;
    bit         expAck;
    logic [7:0] expReg;
  } wrVec_t;

  int nChecks = 0, nFails = 0, rdStrobes = 0, wrStrobes = 0;
  bit busySeen, drvSeen;
  logic [15:0] wrQ[$];
  logic [7:0]  rdQ[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard side: strobes are compared against what the stimulus queued.
  initial forever begin
    @(negedge clock);
    if (!reset) begin
      if (busy) busySeen = 1'b1;
      if (sdaDriven) drvSeen = 1'b1;
      if (readStrobe) rdStrobes++;
      if (writeStrobe) begin
        wrStrobes++;
        if (wrQ.size() == 0) begin
          nChecks++;
          nFails++;
          $display("FAIL spurious writeStrobe: reg %0h data %0h, none expected", regAddress, writeData);
        end else begin
          check("writeStrobe reg/data", {regAddress, writeData}, wrQ.pop_front());
        end
      end
    end
  end

  task automatic busStart();
    #Q sdaM = 1'b1;
    #Q SCL  = 1'b1;
    #Q sdaM = 1'b0;
    #Q SCL  = 1'b0;
  endtask

  task automatic busStop();
    #Q sdaM = 1'b0;
    #Q SCL  = 1'b1;
    #Q sdaM = 1'b1;
    #Q;
  endtask

  task automatic sendBits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      #Q sdaM = b[i];
      #Q SCL  = 1'b1;
      #(2*Q) SCL = 1'b0;
    end
  endtask

  task automatic sendByte(input logic [7:0] b, output bit ack);
    sendBits(b, 8);
    #Q sdaM = 1'b1;
    #Q SCL  = 1'b1;
    #Q ack  = ~sdaBus;
    #Q SCL  = 1'b0;
  endtask

  task automatic recvByte(input bit mNack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      #Q sdaM = 1'b1;
      #Q SCL  = 1'b1;
      #Q b[i] = sdaBus;
      #Q SCL  = 1'b0;
    end
    #Q sdaM = mNack;
    #Q SCL  = 1'b1;
    #(2*Q) SCL = 1'b0;
  endtask

  initial begin
    wrVec_t     vecs[5];
    bit         ack;
    logic [7:0] rb, r1;
    int         rdBase, wrBase;

    vecs[0] = '{8'h78, 8'h10, 2, 8'hA5, 8'h5A, 1'b1, 8'h12};
    vecs[1] = '{8'h78, 8'hFF, 2, 8'h11, 8'h22, 1'b1, 8'h01};  // pointer wraps
    vecs[2] = '{8'h7A, 8'h00, 0, 8'h00, 8'h00, 1'b0, 8'h01};  // wrong address
    vecs[3] = '{8'h00, 8'h05, 1, 8'h99, 8'h00, 1'b0, 8'h01};  // general call
    vecs[4] = '{8'h78, 8'h7F, 1, 8'hC3, 8'h00, 1'b1, 8'h80};

    repeat (3) @(negedge clock);
    check("reset sdaDriven", sdaDriven, 0);
    check("reset busy", busy, 0);
    check("reset regAddress", regAddress, 0);
    check("reset writeData", writeData, 0);
    check("reset writeStrobe", writeStrobe, 0);
    check("reset readStrobe", readStrobe, 0);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    for (int v = 0; v < 5; v++) begin
      busySeen = 1'b0;
      drvSeen  = 1'b0;
      wrBase   = wrStrobes;
      r1       = vecs[v].regB + 8'd1;
      if (vecs[v].expAck && vecs[v].nData > 0) wrQ.push_back({vecs[v].regB, vecs[v].d0});
      if (vecs[v].expAck && vecs[v].nData > 1) wrQ.push_back({r1, vecs[v].d1});
      busStart();
      sendByte(vecs[v].dev, ack);
      check($sformatf("v%0d address ack", v), ack, vecs[v].expAck);
      sendByte(vecs[v].regB, ack);
      check($sformatf("v%0d register ack", v), ack, vecs[v].expAck);
      for (int d = 0; d < vecs[v].nData; d++) begin
        sendByte(d == 0 ? vecs[v].d0 : vecs[v].d1, ack);
        check($sformatf("v%0d data%0d ack", v, d), ack, vecs[v].expAck);
      end
      busStop();
      #(4*Q);
      check($sformatf("v%0d busy seen", v), busySeen, vecs[v].expAck);
      check($sformatf("v%0d sda driven seen", v), drvSeen, vecs[v].expAck);
      check($sformatf("v%0d write strobes", v), wrStrobes - wrBase, vecs[v].expAck ? vecs[v].nData : 0);
      check($sformatf("v%0d regAddress", v), regAddress, vecs[v].expReg);
      check($sformatf("v%0d busy after stop", v), busy, 0);
      check($sformatf("v%0d sda released", v), sdaDriven, 0);
    end

    // Set pointer, repeated START, read two bytes (ACK then NACK).
    rdBase = rdStrobes;
    busStart();
    sendByte(8'h78, ack); check("rd address ack", ack, 1);
    sendByte(8'h20, ack); check("rd register ack", ack, 1);
    busStart();
    sendByte(8'h79, ack); check("rd read-address ack", ack, 1);
    #Q check("rd busy", busy, 1);
    rdQ.push_back(8'h40);
    rdQ.push_back(8'h41);
    recvByte(1'b0, rb); check("rd byte0", rb, rdQ.pop_front());
    recvByte(1'b1, rb); check("rd byte1", rb, rdQ.pop_front());
    #Q check("rd busy after nack", busy, 0);
    busStop();
    #(4*Q);
    check("rd readStrobes", rdStrobes - rdBase, 2);
    check("rd regAddress", regAddress, 8'h21);
    check("rd sda released", sdaDriven, 0);

    // STOP four bits into a data byte.
    wrBase = wrStrobes;
    busStart();
    sendByte(8'h78, ack); check("abort address ack", ack, 1);
    sendByte(8'h30, ack); check("abort register ack", ack, 1);
    sendBits(8'hA0, 4);
    busStop();
    #(4*Q);
    check("abort write strobes", wrStrobes - wrBase, 0);
    check("abort state idle", dut.state, 0);
    check("abort sda released", sdaDriven, 0);
    check("abort busy", busy, 0);
    check("abort regAddress", regAddress, 8'h30);

    // Reset while transmitting a 0 bit (readData 0x50), then a clean read.
    busStart();
    sendByte(8'h79, ack); check("rst address ack", ack, 1);
    #Q check("rst driving bit7", sdaDriven, 1);
    @(negedge clock) reset = 1'b1;
    @(posedge clock) #1;
    check("rst sda released next cycle", sdaDriven, 0);
    check("rst busy", busy, 0);
    @(negedge clock) reset = 1'b0;
    check("rst regAddress", regAddress, 0);
    rdBase = rdStrobes;
    busStart();
    sendByte(8'h79, ack); check("post-rst address ack", ack, 1);
    rdQ.push_back(8'h20);
    recvByte(1'b1, rb); check("post-rst byte", rb, rdQ.pop_front());
    busStop();
    #(4*Q);
    check("post-rst readStrobes", rdStrobes - rdBase, 1);
    check("post-rst busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
